// File: rtl/and_gate_env_mealy_pkg.sv
// Shared types and encodings for the AND-gate environment controller.
package and_gate_env_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_WAIT_OUT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_WRONG   = 2'd2;
  localparam logic [1:0] ERR_UNEXP   = 2'd3;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/and_gate_env_mealy_if.sv
// Transition-event bus between the environment (master) and the gate (slave).
interface and_gate_env_mealy_if;
  import and_gate_env_pkg::*;

  logic a_P;
  logic a_M;
  logic b_P;
  logic b_M;
  logic out_P;
  logic out_M;

  modport master (
    output a_P, a_M, b_P, b_M,
    input  out_P, out_M
  );

  modport slave (
    input  a_P, a_M, b_P, b_M,
    output out_P, out_M
  );

endinterface

// File: rtl/and_gate_env_mealy_watchdog.sv
// Response watchdog: clear/enable counter flagging the last allowed wait cycle.
module and_gate_env_watchdog
  import and_gate_env_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Count enabled wait cycles, saturating at the last allowed one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Expired during the TIMEOUT-th enabled cycle, so the FSM leaves at the
  // very edge where the count would reach TIMEOUT.
  assign expired = en & (cnt_q == LAST);

endmodule

// File: rtl/and_gate_env_mealy.sv
// Environment controller: emits AND-gate input events and checks the replies.
module and_gate_env_mealy
  import and_gate_env_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic                 cmd_sel,
  output logic                 cmd_ready,
  and_gate_env_mealy_if.master evt,
  output logic                 a_lvl,
  output logic                 b_lvl,
  output logic                 out_lvl,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     evt_count
);

  state_t           state_q, state_d;
  logic             accept, out_upd;
  logic [1:0]       code_d;
  logic             a_p_q, a_m_q, b_p_q, b_m_q;
  logic             a_lvl_q, b_lvl_q, out_lvl_q;
  logic [1:0]       err_code_q;
  logic [CNT_W-1:0] cnt_q;
  logic             exp_out, any_out, match_out;
  logic             wdg_clr, wdg_en, wdg_expired;

  // Levels already hold the new value during EMIT, so expected output is
  // simply their AND while in EMIT/WAIT_OUT.
  assign exp_out   = a_lvl_q & b_lvl_q;
  assign any_out   = evt.out_P | evt.out_M;
  assign match_out = exp_out ? (evt.out_P & ~evt.out_M) : (evt.out_M & ~evt.out_P);

  and_gate_env_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdg (
    .clk     (clk),
    .reset   (reset),
    .clr     (wdg_clr),
    .en      (wdg_en),
    .expired (wdg_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic, error classification and acceptance strobes.
  always_comb begin
    state_d = state_q;
    code_d  = ERR_NONE;
    accept  = 1'b0;
    out_upd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_out) begin
          state_d = ST_ERROR;
          code_d  = ERR_UNEXP;
        end else if (cmd_valid) begin
          state_d = ST_EMIT;
          accept  = 1'b1;
        end
      end
      ST_EMIT: begin
        if (exp_out == out_lvl_q) begin
          if (any_out) begin
            state_d = ST_ERROR;
            code_d  = ERR_UNEXP;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (match_out) begin
          state_d = ST_IDLE;
          out_upd = 1'b1;
        end else if (any_out) begin
          state_d = ST_ERROR;
          code_d  = ERR_WRONG;
        end else begin
          state_d = ST_WAIT_OUT;
        end
      end
      ST_WAIT_OUT: begin
        if (match_out) begin
          state_d = ST_IDLE;
          out_upd = 1'b1;
        end else if (any_out) begin
          state_d = ST_ERROR;
          code_d  = ERR_WRONG;
        end else if (wdg_expired) begin
          state_d = ST_ERROR;
          code_d  = ERR_TIMEOUT;
        end
      end
      default: state_d = ST_ERROR;
    endcase
  end

  // Status outputs and watchdog control decoded from the current state.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_EMIT) || (state_q == ST_WAIT_OUT);
    err       = (state_q == ST_ERROR);
    wdg_en    = (state_q == ST_WAIT_OUT);
    wdg_clr   = (state_q != ST_WAIT_OUT);
  end

  // Pulse, level, counter and error-code registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_p_q      <= 1'b0;
      a_m_q      <= 1'b0;
      b_p_q      <= 1'b0;
      b_m_q      <= 1'b0;
      a_lvl_q    <= 1'b0;
      b_lvl_q    <= 1'b0;
      out_lvl_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      cnt_q      <= '0;
    end else begin
      a_p_q <= accept & (cmd_sel == SEL_A) & ~a_lvl_q;
      a_m_q <= accept & (cmd_sel == SEL_A) &  a_lvl_q;
      b_p_q <= accept & (cmd_sel == SEL_B) & ~b_lvl_q;
      b_m_q <= accept & (cmd_sel == SEL_B) &  b_lvl_q;
      if (accept) begin
        if (cmd_sel == SEL_A) a_lvl_q <= ~a_lvl_q;
        else                  b_lvl_q <= ~b_lvl_q;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (out_upd) out_lvl_q <= exp_out;
      if ((state_q != ST_ERROR) && (state_d == ST_ERROR)) err_code_q <= code_d;
    end
  end

  assign evt.a_P   = a_p_q;
  assign evt.a_M   = a_m_q;
  assign evt.b_P   = b_p_q;
  assign evt.b_M   = b_m_q;
  assign a_lvl     = a_lvl_q;
  assign b_lvl     = b_lvl_q;
  assign out_lvl   = out_lvl_q;
  assign err_code  = err_code_q;
  assign evt_count = cnt_q;

endmodule

// File: tb/tb_and_gate_env_mealy.sv
// Directed bench for the AND-gate environment controller.
module tb_and_gate_env_mealy;
  import and_gate_env_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_sel = 1'b0;
  logic        cmd_ready;
  logic        a_lvl, b_lvl, out_lvl, busy, err;
  logic [1:0]  err_code;
  logic [15:0] evt_count;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  and_gate_env_mealy_if ev ();

  and_gate_env_mealy #(
    .TIMEOUT(4),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_sel   (cmd_sel),
    .cmd_ready (cmd_ready),
    .evt       (ev),
    .a_lvl     (a_lvl),
    .b_lvl     (b_lvl),
    .out_lvl   (out_lvl),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code),
    .evt_count (evt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    ev.out_P  = 1'b0;
    ev.out_M  = 1'b0;
    reset     = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // Present a command for one cycle; returns in the EMIT cycle.
  task automatic send(input logic sel);
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    ev.out_P = 1'b0;
    ev.out_M = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_code",  32'(err_code),  32'd0);
    check("rst_cnt",   32'(evt_count), 32'd0);
    check("rst_lvls",  32'({a_lvl, b_lvl, out_lvl}), 32'd0);
    check("rst_pulse", 32'({ev.a_P, ev.a_M, ev.b_P, ev.b_M}), 32'd0);
    do_reset();

    // Toggle a (no output change), then b with combinational out_P.
    send(SEL_A);
    check("t1_aP",    32'({ev.a_P, ev.a_M}), 32'b10);
    check("t1_alvl",  32'(a_lvl),     32'd1);
    check("t1_busy",  32'({busy, cmd_ready}), 32'b10);
    tick();
    check("t1_idle",  32'({ev.a_P, cmd_ready, out_lvl}), 32'b010);
    send(SEL_B);
    check("t1_bP",    32'({ev.b_P, ev.b_M, b_lvl}), 32'b101);
    ev.out_P = 1'b1;
    tick();
    ev.out_P = 1'b0;
    check("t1_outlvl", 32'(out_lvl),  32'd1);
    check("t1_cnt",    32'(evt_count), 32'd2);
    check("t1_ok",     32'({err, cmd_ready, ev.b_P}), 32'b010);

    // From a=b=out=1, toggle a; out_M arrives in the third WAIT_OUT cycle.
    send(SEL_A);
    check("t2_aM",    32'({ev.a_P, ev.a_M, a_lvl}), 32'b010);
    tick();
    check("t2_wait",  32'({busy, ev.a_M, cmd_ready}), 32'b100);
    tick();
    tick();
    ev.out_M = 1'b1;
    tick();
    ev.out_M = 1'b0;
    check("t2_outlvl", 32'(out_lvl), 32'd0);
    check("t2_idle",   32'({cmd_ready, busy, err}), 32'b100);
    check("t2_cnt",    32'(evt_count), 32'd3);

    // Asynchronous reset while waiting for the output.
    send(SEL_A);
    check("t6_aP",    32'(ev.a_P), 32'd1);
    tick();
    check("t6_wait",  32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_lvls",  32'({a_lvl, b_lvl, out_lvl}), 32'd0);
    check("t6_stat",  32'({cmd_ready, busy, err, err_code}), 32'b10000);
    check("t6_cnt",   32'(evt_count), 32'd0);
    tick();
    reset = 1'b1;
    send(SEL_A);
    check("t6_fresh", 32'({ev.a_P, a_lvl}), 32'b11);
    check("t6_cnt1",  32'(evt_count), 32'd1);
    tick();
    check("t6_idle",  32'({cmd_ready, busy}), 32'b10);

    // a=1: toggle b, gate answers with the wrong direction.
    send(SEL_B);
    ev.out_M = 1'b1;
    tick();
    ev.out_M = 1'b0;
    check("t4a_err",  32'({err, err_code}), 32'b110);
    check("t4a_rdy",  32'({cmd_ready, out_lvl}), 32'b00);

    // Both output pulses together while waiting.
    do_reset();
    send(SEL_A);
    tick();
    send(SEL_B);
    tick();
    check("t4b_wait", 32'(busy), 32'd1);
    ev.out_P = 1'b1;
    ev.out_M = 1'b1;
    tick();
    ev.out_P = 1'b0;
    ev.out_M = 1'b0;
    check("t4b_err",  32'({err, err_code, busy}), 32'b1100);

    // Silent gate: timeout at the fourth WAIT_OUT edge.
    do_reset();
    send(SEL_A);
    tick();
    send(SEL_B);
    tick();
    tick();
    tick();
    tick();
    check("t3_pre",   32'({err, busy}), 32'b01);
    tick();
    check("t3_err",   32'({err, err_code, cmd_ready}), 32'b1010);
    ev.out_P = 1'b1;
    tick();
    ev.out_P = 1'b0;
    check("t3_first", 32'(err_code), 32'd1);
    cmd_valid = 1'b1;
    cmd_sel   = SEL_A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_ign", 32'({cmd_ready, ev.a_P, ev.a_M, a_lvl, b_lvl}), 32'b00011);
    end
    cmd_valid = 1'b0;
    check("t3_cnt",   32'(evt_count), 32'd2);

    // Unexpected output event in IDLE, then commands are ignored.
    do_reset();
    ev.out_P = 1'b1;
    tick();
    ev.out_P = 1'b0;
    check("t5_err",   32'({err, err_code}), 32'b111);
    cmd_valid = 1'b1;
    cmd_sel   = SEL_A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_ign", 32'({ev.a_P, ev.a_M, a_lvl, cmd_ready}), 32'b0000);
    end
    cmd_valid = 1'b0;
    check("t5_cnt",   32'(evt_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
